aes_decrypt_core: RTL

//  Iterative AES inverse cipher (FIPS-197 InvCipher): one ciphertext block + key in, one plaintext block out.
//  One round per clock via the existing keyExpansion, addRoundKey, decryptRound and decryptLastRound blocks.

---
 rtl/aes_decrypt_core_if.sv | 30 +++
 rtl/aes_decrypt_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core_if.sv
// aes_decrypt_core_if
// Handshake bundle for the iterative AES inverse cipher.
//   Ingress : in_valid / in_ready with in_cipher[0:127] and in_key[0:32*nk-1]
//   Egress  : out_valid / out_ready with out_plain[0:127]
//   Status  : busy (core is working on a block)
// Bit 0 of every data vector is the MSB of byte 0.
// The master modport is the side that supplies ciphertext and consumes
// plaintext; the slave modport is the decrypt core.
interface aes_decrypt_core_if #(
   parameter int nk = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [0:127]     in_cipher;
   logic [0:32*nk-1] in_key;
   logic             out_valid;
   logic             out_ready;
   logic [0:127]     out_plain;
   logic             busy;

   modport master (
      output in_valid, in_cipher, in_key, out_ready,
      input  in_ready, out_valid, out_plain, busy
   );

   modport slave (
      input  in_valid, in_cipher, in_key, out_ready,
      output in_ready, out_valid, out_plain, busy
   );
endinterface

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core
// Iterative AES inverse cipher: one ciphertext block plus key in, one
// plaintext block out, one round per clock. The finished block is held on
// out_plain until the consumer accepts it.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - aes_decrypt_core_if.slave (valid/ready in, valid/ready out, busy)
//   HEX2/HEX1/HEX0 [6:0] - only when AES_DEC_HEX_EN is defined: decimal
//          value of the last plaintext byte on three active-low 7-seg digits
// Parameters: nk = key words (4/6/8), nr = rounds (10/12/14, nk+6).
// Optional feature macro: AES_DEC_HEX_EN (undefined by default).
module aes_decrypt_core #(
   parameter int nk = 4,
   parameter int nr = 10
) (
   input  logic clk,
   input  logic rst,
`ifdef AES_DEC_HEX_EN
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
`endif
   aes_decrypt_core_if.slave bus
);

   typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

   state_t                 state;
   logic [0:127]           stateReg;
   logic [0:32*nk-1]       keyReg;
   logic [4:0]             round;
   logic                   inReadyReg;
   logic                   outValidReg;
   logic [0:127]           outPlainReg;
   logic                   busyReg;
   logic [0:128*(nr+1)-1]  keySchedule;
   logic [0:127]           lastPlain;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gfMul(r, r);
         if (i != 0) r = gfMul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] v;
      v = gfInv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   // Undo the affine map first, then invert in GF(2^8).
   function automatic logic [7:0] invSbox(input logic [7:0] y);
      logic [7:0] x;
      x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
      return gfInv(x);
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Full schedule; round key r is ks[128*r +: 128].
   function automatic logic [0:128*(nr+1)-1] keyExpansion(input logic [0:32*nk-1] key);
      logic [0:128*(nr+1)-1] ks;
      logic [31:0]           temp;
      logic [7:0]            rc;
      ks = '0;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) ks[32*i +: 32] = key[32*i +: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         temp = ks[32*(i-1) +: 32];
         if (i % nk == 0) begin
            temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            temp = subWord(temp);
         end
         ks[32*i +: 32] = ks[32*(i-nk) +: 32] ^ temp;
      end
      return ks;
   endfunction

   // InvShiftRows then InvSubBytes; byte i sits at row i%4, column i/4.
   function automatic logic [0:127] invShiftSub(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r + 4*((c + r) % 4)) +: 8] = invSbox(s[8*(r + 4*c) +: 8]);
      return o;
   endfunction

   function automatic logic [0:127] invMixColumns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8];
         a1 = s[32*c + 8 +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c +: 8]      = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
         o[32*c + 8 +: 8]  = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
         o[32*c + 16 +: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
         o[32*c + 24 +: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [0:127] decryptRound(input logic [0:127] s, input logic [0:127] rk);
      return invMixColumns(invShiftSub(s) ^ rk);
   endfunction

   function automatic logic [0:127] decryptLastRound(input logic [0:127] s, input logic [0:127] rk);
      return invShiftSub(s) ^ rk;
   endfunction

   // The schedule is derived from the latched key, so the input key bus may
   // change freely once a block has been accepted.
   assign keySchedule = keyExpansion(keyReg);
   assign lastPlain   = decryptLastRound(stateReg, keySchedule[0 +: 128]);

   // Main sequencer: accept a block in IDLE, whiten with the last round key,
   // run nr-1 full inverse rounds counting the round index down, finish with
   // the short round and hold the result in DONE until the consumer takes it.
   // Handshake and busy flags are registered alongside the state so they
   // change exactly on the transitions that define them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         stateReg    <= '0;
         keyReg      <= '0;
         round       <= '0;
         inReadyReg  <= 1'b1;
         outValidReg <= 1'b0;
         outPlainReg <= '0;
         busyReg     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  stateReg   <= bus.in_cipher;
                  keyReg     <= bus.in_key;
                  inReadyReg <= 1'b0;
                  busyReg    <= 1'b1;
                  state      <= INIT;
               end
            end
            INIT: begin
               stateReg <= stateReg ^ keySchedule[128*nr +: 128];
               round    <= 5'(nr - 1);
               state    <= ROUND;
            end
            ROUND: begin
               stateReg <= decryptRound(stateReg, keySchedule[128*round +: 128]);
               round    <= round - 5'd1;
               if (round == 5'd1) state <= FINAL;
            end
            FINAL: begin
               stateReg    <= lastPlain;
               outPlainReg <= lastPlain;
               outValidReg <= 1'b1;
               busyReg     <= 1'b0;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  outValidReg <= 1'b0;
                  outPlainReg <= '0;
                  inReadyReg  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = inReadyReg;
   assign bus.out_valid = outValidReg;
   assign bus.out_plain = outPlainReg;
   assign bus.busy      = busyReg;

`ifdef AES_DEC_HEX_EN
   logic [7:0] hexByte;
   logic [7:0] hundreds, tens, ones;

   function automatic logic [6:0] binaryToSevenSegment(input logic [7:0] d);
      case (d)
         8'd0:    return 7'b1000000;
         8'd1:    return 7'b1111001;
         8'd2:    return 7'b0100100;
         8'd3:    return 7'b0110000;
         8'd4:    return 7'b0011001;
         8'd5:    return 7'b0010010;
         8'd6:    return 7'b0000010;
         8'd7:    return 7'b1111000;
         8'd8:    return 7'b0000000;
         8'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Capture the last plaintext byte as the block enters DONE so the display
   // keeps showing it after the consumer has taken the block.
   always_ff @(posedge clk) begin
      if (rst) hexByte <= '0;
      else if (state == FINAL) hexByte <= lastPlain[120 +: 8];
   end

   assign hundreds = hexByte / 8'd100;
   assign tens     = (hexByte / 8'd10) % 8'd10;
   assign ones     = hexByte % 8'd10;
   assign HEX2     = binaryToSevenSegment(hundreds);
   assign HEX1     = binaryToSevenSegment(tens);
   assign HEX0     = binaryToSevenSegment(ones);
`else
   // Display outputs are not present in this build.
`endif

endmodule
